// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dual-master memory arbiter.
package dm_arb_pkg;

  localparam int ADDR_W       = 10;  // word address, carried on bits [11:2]
  localparam int DATA_W       = 32;
  localparam int LOCK_MAX_DEF = 16;  // default cap on consecutive locked grants
  localparam int CNT_W        = 8;   // wide enough for LOCK_MAX up to 255

  typedef enum logic {
    S_RR   = 1'b0,  // plain round-robin between the two masters
    S_LOCK = 1'b1   // owner keeps the bus while it requests
  } state_e;

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins; when both
// request, the one that was not granted last wins. Output is one-hot or zero.
module dm_arb_rr (
  input  logic [1:0] req,
  input  logic       last,  // index of the master granted most recently
  output logic [1:0] pick
);

  assign pick[0] = req[0] & (~req[1] | last);
  assign pick[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dm_arb.sv
// Dual-master arbiter in front of a single-port memory with combinational
// read data. One access per cycle, read data registered with 1-cycle latency.
// The memory itself lives outside this block.
// Optional feature: define DM_ARB_LOCK_EN to compile in grant locking
// (a master holding lock keeps the bus for up to LOCK_MAX grants).
module dm_arb
  import dm_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W+1:2] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W+1:2] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W+1:2] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        rr_pick;
  logic [1:0]        gnt;
  logic [1:0]        rd_gnt;
  logic              last_q, last_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign req = {m1_req, m0_req};
  assign we  = {m1_we, m0_we};

`ifdef DM_ARB_LOCK_EN
  logic [1:0]       lock;
  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  assign lock = {m1_lock, m0_lock};
`else
  // Without locking the arbiter is pure round-robin; the lock pins and the
  // lock limit have no effect and are only sunk here.
  logic lock_unused;
  localparam int lock_max_unused = LOCK_MAX;

  assign lock_unused = m0_lock ^ m1_lock;
`endif

  dm_arb_rr u_rr (
    .req  (req),
    .last (last_q),
    .pick (rr_pick)
  );

  // Grant decision: round-robin pick, overridden by a locked owner, and
  // forced off during reset so no access (in particular no write) leaks out.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    gnt = rr_pick;
`ifdef DM_ARB_LOCK_EN
    if (state_q == S_LOCK && req[owner_q]) begin
      gnt = owner_q ? 2'b10 : 2'b01;
    end
`endif
    if (rst) begin
      gnt = 2'b00;
    end
  end

  assign rd_gnt = gnt & ~we;

  // Route the winner onto the memory port; idle bus drives zeros.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt[0]) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_din  = m0_wdata;
    end else if (gnt[1]) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_din  = m1_wdata;
    end
  end

  // Next state of the round-robin pointer and the read-return path.
  always_comb begin
    last_d   = last_q;
    rdata_d  = rdata_q;
    rvalid_d = rd_gnt;
    if (|gnt) begin
      last_d = gnt[1];
    end
    if (|rd_gnt) begin
      rdata_d = mem_dout;
    end
  end

  // Round-robin pointer and read-return registers, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      last_q   <= 1'b1;  // m0 wins the first contested cycle
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // A read granted just before reset must not surface while reset is held.
  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid_q[0] & ~rst;
  assign m1_rvalid = rvalid_q[1] & ~rst;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

`ifdef DM_ARB_LOCK_EN
  // Lock FSM next state: enter on a locked grant, leave when the owner drops
  // lock or req, or when it has used its quota while the other master waits.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_RR: begin
        if (|(gnt & lock)) begin
          state_d    = S_LOCK;
          owner_d    = gnt[1];
          lock_cnt_d = CNT_W'(1);
        end
      end
      S_LOCK: begin
        if (req[owner_q]) begin
          if (lock_cnt_q != CNT_W'(LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
          // Quota exhausted with this grant: pointer now favours the other
          // master, so returning to S_RR hands it the next cycle.
          if (!lock[owner_q] ||
              ((int'(lock_cnt_q) + 1 >= LOCK_MAX) && req[~owner_q])) begin
            state_d    = S_RR;
            lock_cnt_d = '0;
          end
        end else begin
          state_d    = S_RR;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_RR;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Lock FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RR;
      owner_q    <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arb.sv
// Self-checking bench for dm_arb: table of per-cycle vectors with expected
// grants, a bench-side memory model, and a queue of expected read data.
// The lock section runs only when DM_ARB_LOCK_EN is defined (LOCK_MAX=4).
module tb_dm_arb;
  import dm_arb_pkg::*;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic [1:0]  g;  // expected {m1_gnt, m0_gnt}
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [11:2] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_din, mem_dout;
  logic        mem_we;

  dm_arb #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // External memory seen by the DUT, preloaded with pat() while init_en is high.
  logic [31:0] mem [1024];
  logic        init_en;
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr];

  int          n_vec;
  int          n_err;
  logic [31:0] ref_mem [1024];
  logic [31:0] sb [$];
  logic [1:0]  rv_pend;
  logic [31:0] exp_rdata;
  vec_t        tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic [1:0] rq,
                              input logic [1:0] w, input logic [1:0] lk,
                              input logic [11:0] ba0, input logic [31:0] d0,
                              input logic [11:0] ba1, input logic [31:0] d1,
                              input logic [1:0] g);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.we = w; v.lock = lk;
    v.a0 = ba0[11:2]; v.d0 = d0; v.a1 = ba1[11:2]; v.d1 = d1; v.g = g;
    return v;
  endfunction

  // Drive one cycle, check at the falling edge, update the model, step the clock.
  task automatic apply(input vec_t v);
    logic        e_we;
    logic [31:0] e_addr, e_din, data;
    rst = v.rst;
    m0_req = v.req[0]; m0_we = v.we[0]; m0_lock = v.lock[0]; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.req[1]; m1_we = v.we[1]; m1_lock = v.lock[1]; m1_addr = v.a1; m1_wdata = v.d1;
    @(negedge clk);
    check({v.name, "/gnt"}, {30'd0, m1_gnt, m0_gnt}, {30'd0, v.g});
    e_we = 1'b0; e_addr = '0; e_din = '0;
    if (v.g[0]) begin
      e_we = v.we[0]; e_addr = 32'(v.a0); e_din = v.d0;
    end else if (v.g[1]) begin
      e_we = v.we[1]; e_addr = 32'(v.a1); e_din = v.d1;
    end
    check({v.name, "/mem_we"}, {31'd0, mem_we}, {31'd0, e_we});
    check({v.name, "/mem_addr"}, 32'(mem_addr), e_addr);
    check({v.name, "/mem_din"}, mem_din, e_din);
    check({v.name, "/rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, {30'd0, (v.rst ? 2'b00 : rv_pend)});
    if (rv_pend != 2'b00) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL %s/sb: got empty queue expected read data", v.name);
      end else begin
        data = sb.pop_front();
        if (!v.rst) exp_rdata = data;
      end
    end
    if (!v.rst) begin
      check({v.name, "/m0_rdata"}, m0_rdata, exp_rdata);
      check({v.name, "/m1_rdata"}, m1_rdata, exp_rdata);
    end
    if (v.rst) begin
      exp_rdata = '0;
      rv_pend   = 2'b00;
      sb.delete();
    end else begin
      rv_pend = v.g & ~v.we;
      if (v.g != 2'b00) begin
        if (e_we) ref_mem[e_addr[9:0]] = e_din;
        else sb.push_back(ref_mem[e_addr[9:0]]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; rv_pend = 2'b00; exp_rdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    rst = 1'b1; init_en = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    @(posedge clk);
    #1;
    init_en = 1'b0;

    // Reset with a write presented: dropped.
    tbl.push_back(mk("rst_wr",   1, 2'b11, 2'b01, 2'b00, 12'h010, 32'h12345678, 12'h000, 0, 2'b00));
    tbl.push_back(mk("rst_idle", 1, 2'b00, 2'b00, 2'b00, 12'h000, 0, 12'h000, 0, 2'b00));
    // Write then read back on m0.
    tbl.push_back(mk("s1_wr",    0, 2'b01, 2'b01, 2'b00, 12'h004, 32'hDEADBEEF, 12'h000, 0, 2'b01));
    tbl.push_back(mk("s1_rd",    0, 2'b01, 2'b00, 2'b00, 12'h004, 0, 12'h000, 0, 2'b01));
    tbl.push_back(mk("s1_rv",    0, 2'b00, 2'b00, 2'b00, 12'h000, 0, 12'h000, 0, 2'b00));
    tbl.push_back(mk("s1_hold",  0, 2'b00, 2'b00, 2'b00, 12'h000, 0, 12'h000, 0, 2'b00));
    // Address hit by the dropped write still holds its preload.
    tbl.push_back(mk("s4_rd",    0, 2'b01, 2'b00, 2'b00, 12'h010, 0, 12'h000, 0, 2'b01));
    tbl.push_back(mk("s4_rv",    0, 2'b00, 2'b00, 2'b00, 12'h000, 0, 12'h000, 0, 2'b00));
    // Both masters reading back-to-back from reset: strict alternation, m0 first.
    tbl.push_back(mk("s2_rst",   1, 2'b00, 2'b00, 2'b00, 12'h000, 0, 12'h000, 0, 2'b00));
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(mk("s2_rr", 0, 2'b11, 2'b00, 2'b00, 12'(12'h100 + 4 * i), 0,
                       12'(12'h200 + 4 * i), 0, (i % 2 == 0) ? 2'b01 : 2'b10));
    end
    // Identical addresses arbitrate normally.
    tbl.push_back(mk("same_rd",  0, 2'b11, 2'b00, 2'b00, 12'h040, 0, 12'h040, 0, 2'b01));
    tbl.push_back(mk("same_rd2", 0, 2'b11, 2'b00, 2'b00, 12'h040, 0, 12'h040, 0, 2'b10));
    tbl.push_back(mk("same_wr",  0, 2'b11, 2'b11, 2'b00, 12'h040, 32'hAAAA5555, 12'h040, 32'h5555AAAA, 2'b01));
    // Lone requester wins regardless of the pointer.
    tbl.push_back(mk("m1_only",  0, 2'b10, 2'b00, 2'b00, 12'h000, 0, 12'h040, 0, 2'b10));
    tbl.push_back(mk("m1_only2", 0, 2'b10, 2'b00, 2'b00, 12'h000, 0, 12'h044, 0, 2'b10));
    // Reset right after a granted read kills the pending rvalid and rdata.
    tbl.push_back(mk("s5_rd",    0, 2'b01, 2'b00, 2'b00, 12'h080, 0, 12'h000, 0, 2'b01));
    tbl.push_back(mk("s5_rst",   1, 2'b01, 2'b00, 2'b00, 12'h080, 0, 12'h000, 0, 2'b00));
    tbl.push_back(mk("s5_post",  0, 2'b00, 2'b00, 2'b00, 12'h000, 0, 12'h000, 0, 2'b00));
`ifdef DM_ARB_LOCK_EN
    // m1 locks: 4 grants (LOCK_MAX) then m0 gets the bus.
    tbl.push_back(mk("l_first",  0, 2'b11, 2'b00, 2'b10, 12'h300, 0, 12'h304, 0, 2'b01));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk("l_own1", 0, 2'b11, 2'b00, 2'b10, 12'h300, 0, 12'h304, 0, 2'b10));
    end
    tbl.push_back(mk("l_max",    0, 2'b11, 2'b00, 2'b10, 12'h300, 0, 12'h304, 0, 2'b01));
    // Lock drop: owner keeps this cycle, round-robin resumes next.
    tbl.push_back(mk("l_relock", 0, 2'b11, 2'b00, 2'b10, 12'h300, 0, 12'h304, 0, 2'b10));
    tbl.push_back(mk("l_drop",   0, 2'b11, 2'b00, 2'b00, 12'h300, 0, 12'h304, 0, 2'b10));
    tbl.push_back(mk("l_rr",     0, 2'b11, 2'b00, 2'b00, 12'h300, 0, 12'h304, 0, 2'b01));
    // Owner drops req: other master granted in the same cycle.
    tbl.push_back(mk("l_m1",     0, 2'b11, 2'b00, 2'b01, 12'h308, 0, 12'h30C, 0, 2'b10));
    tbl.push_back(mk("l_m0lk",   0, 2'b11, 2'b00, 2'b01, 12'h308, 0, 12'h30C, 0, 2'b01));
    tbl.push_back(mk("l_m0own",  0, 2'b11, 2'b00, 2'b01, 12'h308, 0, 12'h30C, 0, 2'b01));
    tbl.push_back(mk("l_reqdrp", 0, 2'b10, 2'b00, 2'b01, 12'h308, 0, 12'h30C, 0, 2'b10));
    tbl.push_back(mk("l_after",  0, 2'b11, 2'b00, 2'b00, 12'h308, 0, 12'h30C, 0, 2'b01));
`else
    // Lock ignored: strict alternation even with m0 asserting lock.
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(mk("s6_nolock", 0, 2'b11, 2'b00, 2'b01, 12'h300, 0, 12'h304, 0,
                       (i % 2 == 0) ? 2'b01 : 2'b10));
    end
`endif
    tbl.push_back(mk("tail",     0, 2'b00, 2'b00, 2'b00, 12'h000, 0, 12'h000, 0, 2'b00));

    foreach (tbl[i]) apply(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_arb.md
DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameter LOCK_MAX, default 16, SHALL set the maximum number of consecutive locked grants to one master (range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 m0_req, m1_req  input  1 each  SHALL flag an access request.
REQ-005 m0_we, m1_we  input  1 each  SHALL select write (1) or read (0).
REQ-006 m0_addr, m1_addr  input  [11:2] each  SHALL be the word address.
REQ-007 m0_wdata, m1_wdata  input  32 each  SHALL be the write data.
REQ-008 m0_lock, m1_lock  input  1 each  SHALL request grant retention; these ports are always present.
REQ-009 m0_gnt, m1_gnt  output  1 each  SHALL flag that the request is accepted in this cycle (combinational).
REQ-010 m0_rvalid, m1_rvalid  output  1 each  SHALL pulse when read data is valid.
REQ-011 m0_rdata, m1_rdata  output  32 each  SHALL carry the read data; the register is shared and is fanned out to both ports.
REQ-012 mem_addr  output  [11:2]  SHALL drive the memory address.
REQ-013 mem_din  output  32  SHALL drive the memory write data.
REQ-014 mem_we  output  1  SHALL drive the memory write enable.
REQ-015 mem_dout  input  32  SHALL carry the memory's combinational read data.

Function
REQ-016 At most one gnt SHALL be high per cycle; gnt SHALL only be high when the matching req is high and rst is 0.
REQ-017 The winner's addr/wdata/we SHALL drive mem_addr/mem_din/mem_we combinationally in the same cycle.
REQ-018 With no grant, mem_we, mem_addr and mem_din SHALL be 0.
REQ-019 A granted write SHALL commit at the end of the grant cycle and SHALL produce no rvalid.
REQ-020 For a granted read, mem_dout SHALL be registered at the end of the grant cycle.
REQ-021 For a granted read, the winner's rvalid SHALL be high for exactly the next cycle.
REQ-022 rdata SHALL hold its value until the next granted read.
REQ-023 Read latency SHALL be 1 cycle; the arbiter SHALL sustain one access per cycle, with no bubbles.
REQ-024 The FSM SHALL have two states: S_RR and S_LOCK; the owner register SHALL be 1 bit.
REQ-025 In S_RR, a single requester SHALL win.
REQ-026 In S_RR with both requesting, the master not granted last SHALL win; the last-grant pointer SHALL update on every grant.
REQ-027 In S_LOCK, the owner SHALL have absolute priority while owner_req is high.
REQ-028 If owner_req is low in S_LOCK, the other master MAY be granted and the state SHALL return to S_RR.
REQ-029 Simultaneous req on both ports with identical addresses SHALL be arbitrated normally; there is no hazard logic.

Reset
REQ-030 While rst is high, gnt SHALL be 0 and mem_we SHALL be 0; a write presented in a reset cycle SHALL be dropped.
REQ-031 The reset state SHALL be: state=S_RR, last_gnt=1 (m0 wins first), lock_cnt=0, rvalid=0, rdata=0.
REQ-032 Reset SHALL override a pending rvalid, and rvalid SHALL be 0 in the cycle after rst.

Configuration
REQ-033 Macro DM_ARB_LOCK_EN SHALL compile in the lock feature.
REQ-034 With DM_ARB_LOCK_EN defined, S_RR SHALL go to S_LOCK(owner=winner) when the winner's gnt and lock are both high.
REQ-035 With DM_ARB_LOCK_EN defined, lock_cnt SHALL count consecutive owner grants.
REQ-036 With DM_ARB_LOCK_EN defined, S_LOCK SHALL return to S_RR when lock drops, when req drops, or when lock_cnt reaches LOCK_MAX while the other req is high; in the LOCK_MAX case the other master SHALL win the next cycle.
REQ-037 Without DM_ARB_LOCK_EN, the lock inputs SHALL be ignored, S_LOCK SHALL be unreachable, and lock_cnt logic SHALL be absent.

Structure
REQ-038 Package dm_arb_pkg SHALL hold ADDR_W=10, DATA_W=32, the state typedef {S_RR, S_LOCK}, and the default LOCK_MAX.
REQ-039 Sub-module dm_arb_rr SHALL be the 2-way round-robin picker (inputs req[1:0], last; outputs one-hot pick).
REQ-040 dm_arb SHALL instantiate the memory externally; the memory is not instantiated inside dm_arb.

Verification
REQ-041 Scenario 1: m0 writes 0xDEADBEEF to addr 0x004 (cycle 1), then reads addr 0x004 -> m0_gnt in both cycles; m0_rvalid high in cycle 3 only; m0_rdata=0xDEADBEEF.
REQ-042 Scenario 2: both masters read continuously for 6 cycles after reset -> grants m0,m1,m0,m1,m0,m1; each rvalid follows its grant by 1 cycle.
REQ-043 Scenario 3 (DM_ARB_LOCK_EN, LOCK_MAX=4): m1 lock+req held, m0 req held -> m1 granted 4 consecutive cycles, then m0 granted.
REQ-044 Scenario 4: rst asserted in a cycle where m0 writes 0x12345678 to addr 0x010 -> no gnt, mem_we=0; a later read of 0x010 returns the prior contents.
REQ-045 Scenario 5: read granted in cycle N, rst asserted in cycle N+1 -> rvalid=0 in N+1 and N+2; rdata=0.
REQ-046 Scenario 6 (without DM_ARB_LOCK_EN): m0 lock+req held with m1 req held -> strict alternation m0,m1,m0,...
